// File: rtl/keen_decode_stage.sv
// rtl/keen_decode_stage.sv - RV32I decode stage with a two-entry skid buffer
module keen_decode_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] MAIN  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } entry_t;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       ready_q;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     dec;
    entry_t     main_src;
    logic       load_main;
    logic       load_skid;
    logic       in_xfer;
    logic       out_xfer;

    assign in_xfer  = in_valid && ready_q;
    assign out_xfer = (state != EMPTY) && out_ready;

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'({in_instr[31:12], 12'b0});
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                dec.fmt = FMT_I;
                dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0110011: dec.fmt = FMT_R;
            default:    dec.fmt = FMT_ILL;
        endcase
        if (dec.fmt != FMT_ILL) dec.illegal = 1'b0;
    end

    // Flush wins over every transfer; a concurrent output transfer is simply consumed.
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        main_src  = dec;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    load_main = 1'b1;
                    state_nx  = MAIN;
                end
                MAIN: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_nx  = SKID;
                    end else if (out_xfer) begin
                        state_nx  = EMPTY;
                    end
                end
                SKID: if (out_xfer) begin
                    load_main = 1'b1;
                    main_src  = skid_q;
                    state_nx  = MAIN;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != SKID);
            if (load_main) main_q <= main_src;
            if (load_skid) skid_q <= dec;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = (state != EMPTY);
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_keen_decode_stage.sv
// tb/tb_keen_decode_stage.sv - directed and random bench for keen_decode_stage
module tb_keen_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_illegal;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [14:0] regs;
        logic        illegal;
    } exp_t;

    exp_t model_q[$];

    always #5 clk = ~clk;

    keen_decode_stage #(.XLEN(32), .ILEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_illegal(out_illegal)
    );

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sgn;
        sgn       = i[31] ? 32'hFFFF_FFFF : 32'h0;
        e.pc      = pc;
        e.regs    = {i[11:7], i[19:15], i[24:20]};
        e.illegal = 1'b0;
        e.imm     = 32'h0;
        case (i[6:0])
            7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = i & 32'hFFFF_F000; end
            7'h6F: begin
                e.fmt = 3'd5;
                e.imm = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                      | (32'(i[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
                e.fmt = 3'd1;
                e.imm = (sgn << 12) | 32'(i[31:20]);
            end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = (sgn << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                      | (32'(i[11:8]) << 1);
            end
            7'h33:   e.fmt = 3'd0;
            default: begin e.fmt = 3'd7; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, compare against the queue model at the falling edge, advance model.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic in_x;
        logic out_x;
        exp_t h;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        if (model_q.size() != 0) begin
            h = model_q[0];
            chk("out_pc", out_pc, h.pc);
            chk("out_imm", out_imm, h.imm);
            chk("out_fmt", 32'(out_fmt), 32'(h.fmt));
            chk("out_regs", 32'({out_rd, out_rs1, out_rs2}), 32'(h.regs));
            chk("out_illegal", 32'(out_illegal), 32'(h.illegal));
        end
        in_x  = v && (model_q.size() < 2);
        out_x = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (out_x) void'(model_q.pop_front());
            if (in_x) model_q.push_back(ref_decode(instr, pc));
        end
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_fmt", 32'(out_fmt), 32'd0);
        chk("rst_out_regs", 32'({out_rd, out_rs1, out_rs2}), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [2:0] fmt);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_fmt"}, 32'(out_fmt), 32'(fmt));
    endtask

    logic [6:0] opcodes [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                                 7'h13, 7'h23, 7'h63, 7'h33, 7'h73};

    initial begin
        logic [31:0] w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values();

        cycle(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
        chk_head("addi", 32'h100, 32'hFFFF_FFFF, 3'd1);
        chk("addi_rd", 32'(out_rd), 32'd1);

        cycle(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0);
        chk_head("sw", 32'h104, 32'hFFFF_FFFC, 3'd2);
        chk("sw_rs", 32'({out_rs1, out_rs2}), 32'({5'd2, 5'd1}));
        cycle(1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0);
        chk_head("lui", 32'h108, 32'h1234_5000, 3'd4);
        chk("lui_rd", 32'(out_rd), 32'd5);
        cycle(1'b1, 32'h80000063, 32'h10C, 1'b1, 1'b0);
        chk_head("beq", 32'h10C, 32'hFFFF_F000, 3'd3);
        cycle(1'b1, 32'h800000EF, 32'h110, 1'b1, 1'b0);
        chk_head("jal", 32'h110, 32'hFFF0_0000, 3'd5);
        chk("jal_rd", 32'(out_rd), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A and B fill the buffer, C waits.
        cycle(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        cycle(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        chk_head("bp_hold_a", 32'h200, 32'h1, 3'd1);
        repeat (4) cycle(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h00000000, 32'h300, 1'b1, 1'b0);
        chk_head("ill0", 32'h300, 32'h0, 3'd7);
        chk("ill0_flag", 32'(out_illegal), 32'd1);
        cycle(1'b1, 32'h0000007F, 32'h304, 1'b1, 1'b0);
        chk_head("ill7f", 32'h304, 32'h0, 3'd7);
        chk("ill7f_flag", 32'(out_illegal), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush from SKID with a new input in the same cycle.
        cycle(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200193, 32'h404, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300213, 32'h408, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'h00500293, 32'h40C, 1'b0, 1'b0);
        chk_head("post_flush", 32'h40C, 32'h5, 3'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset while holding one entry with execute stalled.
        cycle(1'b1, 32'hFFF00093, 32'h500, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 32'h00100113, 32'h504, 1'b0, 1'b0);
        rst = 1'b0;
        chk_reset_values();

        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = opcodes[$urandom_range(0, 9)];
            cycle(1'($urandom_range(0, 3) != 0), w, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/keen_decode_stage.md
# keen_decode_stage

Pipeline stage between fetch and execute that accepts one RV32I instruction word per cycle, classifies its format, extracts register indices, and assembles and sign-extends its immediate to XLEN. It drives the immediate sign-extension datapath and buffers results in a two-entry skid buffer. Both sides use valid/ready handshakes, so fetch and execute stalls are absorbed without combinational ready paths.

## Interface
- `XLEN`, 32, datapath/immediate output width
- `ILEN`, 32, instruction width; only 32 is supported
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous active-high reset
- `flush`  in  1  discard all buffered entries (branch redirect)
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  ILEN  instruction word
- `in_pc`  in  XLEN  instruction address
- `out_valid`  out  1  decoded entry available
- `out_ready`  in  1  execute accepts the entry
- `out_pc`  out  XLEN  address of the decoded instruction
- `out_imm`  out  XLEN  sign-extended immediate
- `out_fmt`  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices: instr[11:7], [19:15], [24:20]
- `out_illegal`  out  1  opcode is not RV32I, or instr[1:0] != 2'b11

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Decode is combinational on `in_instr`. The decoded result is written into the buffer on an input transfer.
- Format is selected by opcode instr[6:0]:
  - 0110111 LUI and 0010111 AUIPC → U
  - 1101111 JAL → J
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM → I
  - 0100011 STORE → S
  - 1100011 BRANCH → B
  - 0110011 OP → R
  - any other opcode → illegal
- Immediate assembly; all formats except U take their sign bit from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - U: {instr[31:12], 12'b0}, with no extension
  - R and illegal: 0
- Illegal instructions still transfer downstream with `out_illegal=1`, `out_fmt=7`, `out_imm=0`. This stage never traps.
- Skid buffer state machine:
  - States: EMPTY (0 entries), MAIN (1 entry), SKID (2 entries). Outputs are driven from the MAIN register.
  - EMPTY: an input transfer loads MAIN → MAIN.
  - MAIN, input only: the input loads SKID → SKID.
  - MAIN, output only → EMPTY.
  - MAIN, input and output together: the input loads MAIN → MAIN.
  - MAIN, neither: hold.
  - SKID, output transfer: SKID moves to MAIN → MAIN.
  - SKID, no output transfer: hold.
  - `in_ready = (state != SKID)`, registered.
  - `out_valid = (state != EMPTY)`.
- Order is strictly FIFO: no entry is dropped or duplicated except on flush or reset.
- `flush` has priority over all transfers:
  - Next state is EMPTY and `in_ready` is 1 next cycle.
  - An input presented in the flush cycle is discarded.
  - An output accepted in the flush cycle counts as consumed.

## Timing
- Latency: instruction accepted at edge N appears on outputs in the cycle following edge N. Throughput is 1 per cycle while `out_ready=1`.
- All outputs are registered. There is no combinational path from `in_*` or `out_ready` to any output.
- Reset, and reset mid-operation:
  - Both entries are discarded and the state is EMPTY.
  - `out_valid=0`, `in_ready=1`.
  - `out_pc`, `out_imm`, `out_rd`, `out_rs1`, `out_rs2` = 0, `out_fmt=0`, `out_illegal=0`.
  - `rst` dominates `flush`.
- While `out_valid=1 && out_ready=0`, every `out_*` signal is held stable.
- Full pressure: with `out_ready=0` held, at most 2 instructions are accepted. `in_ready` falls in the cycle after the second acceptance.

## Test plan
- Reset then `in_instr=0xFFF00093` (addi x1,x0,-1), `in_pc=0x100`, `out_ready=1` → next cycle `out_valid=1`, `out_imm=0xFFFFFFFF`, `out_fmt=1`, `out_rd=1`, `out_pc=0x100`.
- Format sweep, back-to-back, `out_ready=1`:
  - 0xFE112E23 (sw) → `out_imm=0xFFFFFFFC`, fmt 2, rs1=2, rs2=1.
  - 0x123452B7 (lui) → `out_imm=0x12345000`, fmt 4, rd=5.
  - 0x80000063 (beq) → `out_imm=0xFFFFF000`, fmt 3.
  - 0x800000EF (jal) → `out_imm=0xFFF00000`, fmt 5, rd=1.
  - Required response: one output per cycle, in order.
- Backpressure: `out_ready=0`, stream A, B, C → A and B accepted; `in_ready=0` in the cycle after B is accepted; C is held. Raise `out_ready` → A, B, C emerge in order, with no gaps once C is accepted.
- Illegal: `in_instr=0x00000000` and 0x0000007F → `out_illegal=1`, `out_fmt=7`, `out_imm=0`.
- Flush while in SKID with a new input valid in the same cycle → next cycle `out_valid=0`, `in_ready=1`. The next accepted instruction is the first output; no stale entry appears.
- Assert `rst` for 1 cycle while in MAIN with `out_ready=0` → all outputs return to their reset values, `in_ready=1`.
